// File: rtl/tff_consistency_monitor.sv
// rtl/tff_consistency_monitor.sv - golden-model checker for the three-way T flip-flop block
module tff_consistency_monitor #(
    parameter int CW       = 8,
    parameter int TW       = 16,
    parameter int FAULT_TH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clear,
    input  logic          t,
    input  logic          q_sr,
    input  logic          q_jk,
    input  logic          q_d,
    output logic          checking,
    output logic          fault,
    output logic [2:0]    err_flags,
    output logic [CW-1:0] mism_sr,
    output logic [CW-1:0] mism_jk,
    output logic [CW-1:0] mism_d,
    output logic [TW-1:0] toggle_cnt
);

    typedef enum logic [1:0] {IDLE, SYNC, CHECK, FAULT} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TH      = CW'(FAULT_TH);

    state_t        state;
    state_t        state_next;
    logic          golden;
    logic [2:0]    q_vec;
    logic [2:0]    miss;
    logic          hit_th;
    logic          q_maj;
    logic [CW-1:0] cnt     [3];
    logic [CW-1:0] cnt_inc [3];

    // Index 2/1/0 = sr/jk/d, matching err_flags bit order.
    assign q_vec   = {q_sr, q_jk, q_d};
    assign q_maj   = (q_sr & q_jk) | (q_sr & q_d) | (q_jk & q_d);
    assign mism_sr = cnt[2];
    assign mism_jk = cnt[1];
    assign mism_d  = cnt[0];

    always_comb begin
        miss   = '0;
        hit_th = 1'b0;
        for (int k = 0; k < 3; k++) begin
            // Case inequality so an X/Z flop output is flagged rather than masked.
            miss[k]    = (q_vec[k] !== golden);
            cnt_inc[k] = (miss[k] && cnt[k] != CNT_MAX) ? cnt[k] + CW'(1) : cnt[k];
            if (cnt_inc[k] >= TH) begin
                hit_th = 1'b1;
            end
        end

        state_next = state;
        case (state)
            IDLE:    if (en) state_next = SYNC;
            SYNC:    state_next = en ? CHECK : IDLE;
            CHECK: begin
                if (hit_th) begin
                    state_next = FAULT;
                end else if (!en) begin
                    state_next = IDLE;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= IDLE;
            checking   <= 1'b0;
            fault      <= 1'b0;
            golden     <= 1'b0;
            err_flags  <= 3'b000;
            toggle_cnt <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            state    <= state_next;
            checking <= (state_next == CHECK);
            fault    <= (state_next == FAULT);
            case (state)
                // Majority of the pre-edge outputs, toggled, is the post-edge value.
                SYNC: golden <= q_maj ^ t;
                CHECK: begin
                    for (int k = 0; k < 3; k++) begin
                        cnt[k] <= cnt_inc[k];
                    end
                    err_flags <= err_flags | miss;
                    golden    <= golden ^ t;
                    if (t) begin
                        toggle_cnt <= toggle_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_consistency_monitor.sv
// tb/tb_tff_consistency_monitor.sv - scoreboard bench for tff_consistency_monitor
module tb_tff_consistency_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic clear = 1'b0;
    logic t = 1'b0;
    logic q_sr = 1'b0;
    logic q_jk = 1'b0;
    logic q_d = 1'b0;

    logic       a_checking, a_fault;
    logic [2:0] a_flags;
    logic [7:0] a_sr, a_jk, a_d;
    logic [15:0] a_tog;

    logic       b_checking, b_fault;
    logic [2:0] b_flags;
    logic [1:0] b_sr, b_jk, b_d;
    logic [1:0] b_tog;

    always #5 clk = ~clk;

    tff_consistency_monitor #(.CW(8), .TW(16), .FAULT_TH(4)) dut_a (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .t(t),
        .q_sr(q_sr), .q_jk(q_jk), .q_d(q_d),
        .checking(a_checking), .fault(a_fault), .err_flags(a_flags),
        .mism_sr(a_sr), .mism_jk(a_jk), .mism_d(a_d), .toggle_cnt(a_tog)
    );

    tff_consistency_monitor #(.CW(2), .TW(2), .FAULT_TH(3)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .t(t),
        .q_sr(q_sr), .q_jk(q_jk), .q_d(q_d),
        .checking(b_checking), .fault(b_fault), .err_flags(b_flags),
        .mism_sr(b_sr), .mism_jk(b_jk), .mism_d(b_d), .toggle_cnt(b_tog)
    );

    typedef struct {
        logic [44:0] a;
        logic [12:0] b;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model: 0=IDLE 1=SYNC 2=CHECK 3=FAULT, counters as plain integers.
    int cw_p[2] = '{8, 2};
    int tw_p[2] = '{16, 2};
    int th_p[2] = '{4, 3};
    int st[2];
    int gold[2];
    int cnt[2][3];
    int flg[2][3];
    int tog[2];
    bit fq = 1'b0;

    task automatic model_edge(input bit r, input bit c, input bit e, input bit tt, input bit [2:0] q);
        for (int i = 0; i < 2; i++) begin
            if (r || c) begin
                st[i] = 0;
                gold[i] = 0;
                tog[i] = 0;
                for (int k = 0; k < 3; k++) begin
                    cnt[i][k] = 0;
                    flg[i][k] = 0;
                end
            end else if (st[i] == 0) begin
                if (e) st[i] = 1;
            end else if (st[i] == 1) begin
                gold[i] = ((int'(q[2]) + int'(q[1]) + int'(q[0])) >= 2 ? 1 : 0) ^ int'(tt);
                st[i] = e ? 2 : 0;
            end else if (st[i] == 2) begin
                bit any = 0;
                for (int k = 0; k < 3; k++) begin
                    if (int'(q[k]) != gold[i]) begin
                        if (cnt[i][k] < (1 << cw_p[i]) - 1) cnt[i][k]++;
                        flg[i][k] = 1;
                    end
                    if (cnt[i][k] >= th_p[i]) any = 1;
                end
                gold[i] = gold[i] ^ int'(tt);
                if (tt) tog[i] = (tog[i] + 1) % (1 << tw_p[i]);
                st[i] = any ? 3 : (e ? 2 : 0);
            end
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input bit tt,
                         input bit [2:0] inj, input bit stuck_d);
        bit [2:0] q;
        exp_t x;
        @(negedge clk);
        q = {fq, fq, fq} ^ inj;
        if (stuck_d) q[0] = 1'b0;
        reset = r;
        clear = c;
        en = e;
        t = tt;
        q_sr = q[2];
        q_jk = q[1];
        q_d = q[0];
        model_edge(r, c, e, tt, q);
        fq = fq ^ tt;
        cyc++;
        x.cyc = cyc;
        x.a = {st[0] == 2, st[0] == 3, flg[0][2] != 0, flg[0][1] != 0, flg[0][0] != 0,
               8'(cnt[0][2]), 8'(cnt[0][1]), 8'(cnt[0][0]), 16'(tog[0])};
        x.b = {st[1] == 2, st[1] == 3, flg[1][2] != 0, flg[1][1] != 0, flg[1][0] != 0,
               2'(cnt[1][2]), 2'(cnt[1][1]), 2'(cnt[1][0]), 2'(tog[1])};
        sb.push_back(x);
    endtask

    // Monitor: compares after every active edge that has a pending expectation.
    initial begin
        exp_t e;
        logic [44:0] act_a;
        logic [12:0] act_b;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act_a = {a_checking, a_fault, a_flags, a_sr, a_jk, a_d, a_tog};
                act_b = {b_checking, b_fault, b_flags, b_sr, b_jk, b_d, b_tog};
                total++;
                if (act_a !== e.a) begin
                    bad++;
                    $display("FAIL inst_a cycle %0d got %h want %h", e.cyc, act_a, e.a);
                end
                total++;
                if (act_b !== e.b) begin
                    bad++;
                    $display("FAIL inst_b cycle %0d got %h want %h", e.cyc, act_b, e.b);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        bit [1:0] pat[4] = '{1, 1, 0, 1};
        // Reset, then a clean run with the 1,1,0,1 pattern and more random toggles.
        drive(1, 0, 0, 0, 3'b000, 0);
        drive(1, 0, 0, 0, 3'b000, 0);
        drive(0, 0, 1, 0, 3'b000, 0);
        drive(0, 0, 1, 0, 3'b000, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, pat[i][0], 3'b000, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 1'($urandom), 3'b000, 0);
        // Single faulty flop: jk inverted for two CHECK cycles.
        drive(0, 0, 1, 1'($urandom), 3'b010, 0);
        drive(0, 0, 1, 1'($urandom), 3'b010, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1'($urandom), 3'b000, 0);
        // Threshold: d stuck at 0, t=1 every cycle, then keep toggling in FAULT.
        for (int i = 0; i < 14; i++) drive(0, 0, 1, 1, 3'b000, 1);
        // Clear with en held high, then re-arm.
        drive(0, 1, 1, 1'($urandom), 3'b000, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 1'($urandom), 3'b000, 0);
        // Saturation on sr, then clear.
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 1'($urandom), 3'b100, 0);
        drive(0, 1, 0, 0, 3'b000, 0);
        // Reset mid-operation with nonzero counters and en still high.
        drive(0, 0, 1, 1, 3'b000, 0);
        drive(0, 0, 1, 1, 3'b000, 0);
        drive(0, 0, 1, 1, 3'b001, 0);
        drive(1, 0, 1, 1, 3'b000, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1'($urandom), 3'b000, 0);
        // Randomized mix of enable drops, injections, clears and resets.
        for (int i = 0; i < 400; i++) begin
            bit [2:0] inj;
            inj[0] = ($urandom_range(0, 15) == 0);
            inj[1] = ($urandom_range(0, 15) == 0);
            inj[2] = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) != 0, 1'($urandom), inj,
                  $urandom_range(0, 49) == 0);
        end
        drive(0, 0, 0, 0, 3'b000, 0);
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tff_consistency_monitor.md
# tff_consistency_monitor

Checker stage placed directly downstream of the three-way T flip-flop block (SR-, JK- and D-based T flip-flops sharing one `T` input). It tracks a golden toggle model, compares all three flop outputs against it every cycle, and keeps per-flop saturating mismatch counters and sticky error flags. It counts toggle requests and enters a latched FAULT state once any flop exceeds a mismatch threshold.

## Interface
- `CW`, 8: width of each mismatch counter.
- `TW`, 16: width of the toggle-request counter.
- `FAULT_TH`, 4: mismatch count that triggers FAULT. Legal range 1..2^CW-1.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset. Applies to all state.
- `en`  in  1  arm or keep checking.
- `clear`  in  1  synchronous clear of counters, flags and state.
- `t`  in  1  same `T` that drives the flop block, sampled on the same edge.
- `q_sr`, `q_jk`, `q_d`  in  1 each  flop outputs under check.
- `checking`  out  1  high while state is CHECK.
- `fault`  out  1  high while state is FAULT.
- `err_flags`  out  3  sticky mismatch flags; bit2 = sr, bit1 = jk, bit0 = d.
- `mism_sr`, `mism_jk`, `mism_d`  out  CW each  saturating mismatch counts.
- `toggle_cnt`  out  TW  count of CHECK cycles with `t`=1; wraps.

## Operation
- States: IDLE, SYNC, CHECK, FAULT. Encoding is free; outputs are decoded from registers.
- **IDLE**: no checking. Go to SYNC when `en`=1.
- **SYNC**, one cycle:
  - golden <= maj(`q_sr`,`q_jk`,`q_d`) ^ `t`, which matches the flops' post-edge value.
  - Next state is CHECK if `en`=1, otherwise IDLE.
- **CHECK**, every edge:
  - For each flop x, the cycle is a mismatch when `q_x` != golden, using values before the edge.
  - On a mismatch: `mism_x` += 1, saturating at 2^CW-1, and `err_flags[x]` <= 1.
  - golden <= golden ^ `t`.
  - If `t`=1: `toggle_cnt` += 1, wrapping modulo 2^TW.
  - If any post-update `mism_x` >= FAULT_TH, next state is FAULT. This has priority over the `en`=0 exit.
  - Otherwise, if `en`=0, next state is IDLE.
- **FAULT**: no comparison, no counting, all outputs hold. Exits only on `clear` or `reset`.
- Counters and flags are kept across IDLE/CHECK re-arms. Re-arming always passes through SYNC.
- Priority per edge: `reset` > `clear` > state logic.
- `clear` action: counters = 0, flags = 0, golden = 0, state = IDLE. `clear` and `en` high together give IDLE; SYNC starts on the next edge only if `en` is still 1.
- X or Z on `q_x`, for example from an SR illegal state, counts as a mismatch. Compare with `!==`-equivalent semantics in simulation only; synthesis treats the compare as `!=`.

## Timing
- Reset values: `checking`=0, `fault`=0, `err_flags`=3'b000, all `mism_*`=0, `toggle_cnt`=0, golden=0, state IDLE.
- `en` rises at edge k: SYNC holds over k..k+1, and `checking`=1 after edge k+1. The first comparison happens at edge k+2.
- Mismatch latency: a bad `q_x` present before edge n is reflected in `mism_x` and `err_flags` after edge n.
- FAULT entry: `fault`=1 after the same edge on which the threshold-reaching increment occurs.
- `reset` mid-CHECK: all outputs return to reset values after that edge. No partial update occurs.
- `clear` in FAULT: `fault`=0 after the edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset, clean run**: reset 2 cycles, `en`=1, `t` pattern 1,1,0,1 driving a correct flop block. Required: `err_flags`=000, all `mism_*`=0, `toggle_cnt`=3, `checking`=1.
- **Single faulty flop**: force `q_jk` inverted for 2 CHECK cycles. Required: `mism_jk`=2, `err_flags`=3'b010, other counters 0, no fault.
- **Threshold**: FAULT_TH=4, `q_d` stuck at 0 while `t`=1 every cycle. Required: `mism_d` increments every second cycle; `fault`=1 after the edge where `mism_d` reaches 4; counters then frozen while `t` keeps toggling.
- **Clear and re-arm**: `clear`=1 for 1 cycle in FAULT with `en`=1. Required: all zero, IDLE, then SYNC, then CHECK with `checking`=1 two edges after clear drops.
- **Saturation and wrap**: CW=2, FAULT_TH=3. Inject mismatches on `q_sr` in CHECK; `mism_sr` may not exceed 3 and FAULT is reached at 3. With TW=2 and a correct block, 5 toggles give `toggle_cnt`=1.
- **Reset mid-operation**: assert `reset` during CHECK with nonzero counters. Required: all outputs 0 after the edge, and state IDLE even though `en`=1.
